ram_d_clr: RTL and testbench
============================

# ram_d_clr

Parametrised single-clock dual-port RAM for the decoder's neighbour/side-info storage: intra prediction modes, ref_idx, MV candidates. It is the successor to the existing simple dual-port RAM and adds four things:
- a built-in clear engine that sweeps every entry to a programmable value after reset or on request;
- a `ready` status output;
- optional write-to-read forwarding on port B;
- a parametrised clear value.

Port A is read/write and port B is read-only. It is intended for block-RAM inference.

## Interface
Parameters:
- `addr_bits`, 8: address width; depth is 2^addr_bits entries.
- `data_bits`, 16: word width.
- `clear_val`, 0: `data_bits`-wide value written to every entry by the clear engine.
- `fwd_en`, 1: 1 means a port B read of the address being written on port A returns the new data; 0 means it returns the old data.

Ports (one clock; reset is synchronous and active-high):
- `clk` in 1: clock; all state changes on its rising edge.
- `rst` in 1: synchronous, active-high reset; starts a full clear.
- `clr` in 1: single-cycle request to re-clear the whole RAM; sampled only in READY.
- `en` in 1: access enable for both ports; ignored while clearing.
- `we` in 1: port A write enable; qualified by `en`.
- `addra` in `addr_bits`: port A read/write address.
- `addrb` in `addr_bits`: port B read address.
- `dia` in `data_bits`: port A write data.
- `doa` out `data_bits`: port A registered read data.
- `dob` out `data_bits`: port B registered read data.
- `ready` out 1: 1 means user accesses are accepted; 0 means the clear is in progress.

## Operation
- State machine with two states, CLEAR and READY, plus a clear address counter `clr_addr` of `addr_bits` bits.
- Reset: on an edge with `rst`=1:
  - state goes to CLEAR and `clr_addr` to 0;
  - `doa` and `dob` go to 0 and `ready` to 0;
  - no RAM write happens on that edge;
  - `rst` has priority over everything else.
- CLEAR state:
  - each edge writes `ram[clr_addr] <= clear_val` and increments `clr_addr`;
  - on the edge that writes address 2^addr_bits−1, state goes to READY, `ready` goes to 1, and `clr_addr` wraps to 0;
  - `en`, `we`, `clr`, `addra`, `addrb` and `dia` are ignored;
  - `doa` and `dob` hold their values.
- READY state with `clr`=1:
  - next state is CLEAR, `clr_addr` goes to 0 and `ready` goes to 0;
  - the user access in that same cycle is dropped: no write occurs and `doa`/`dob` hold.
- READY state with `en`=1 and `clr`=0:
  - `doa <= ram[addra]`. Port A is read-first, so a write cycle returns the old contents.
  - If `we`, then `ram[addra] <= dia`.
  - `dob <= ram[addrb]`, except when `fwd_en`=1, `we`=1 and `addrb`==`addra`; then `dob <= dia`.
- READY state with `en`=0: no write, and `doa`/`dob` hold.
- Reset arriving mid-clear restarts the sweep at address 0. `clr` asserted during CLEAR is ignored and is not queued.

## Timing
- Read latency is one cycle on both ports: address and `en` are presented at edge N and data is visible after edge N.
- A write at edge N is visible to a read whose address is presented at edge N+1.
- Clear duration:
  - `ready` is 0 for exactly 2^addr_bits edges after the edge that samples `rst` deasserted, or after the edge that accepts `clr`;
  - `ready` rises after the final clear write.
  - Example: `addr_bits`=8 gives 256 cycles.
- Reset values: `doa`=0, `dob`=0, `ready`=0, state=CLEAR, `clr_addr`=0.

## Test plan
- Reset and clear, with `clear_val`=16'h5A5A and `addr_bits`=4:
  - pulse `rst` for 1 cycle;
  - `ready` is 0 for exactly 16 cycles, then 1;
  - reads of all 16 addresses return 16'h5A5A.
- Basic write/read:
  - write 16'h1234 to address 3, then read address 3 on both ports the next cycle;
  - `doa`=`dob`=16'h1234 one cycle later.
- Same-address collision, with address 7 holding 16'hAAAA:
  - write 16'hBBBB to address 7 with `addrb`=7;
  - `doa`=16'hAAAA;
  - `dob`=16'hBBBB when `fwd_en`=1, or 16'hAAAA when `fwd_en`=0.
- `clr` during traffic:
  - fill the RAM with non-zero data, then assert `clr` together with `en`/`we` writing 16'hFFFF to address 2;
  - the write is dropped, `ready` is low for 2^addr_bits cycles, and all entries read back as `clear_val`;
  - `en`/`we` pulses applied during the clear have no effect.
- Reset mid-clear:
  - assert `rst` at clear cycle 5;
  - the sweep restarts, `ready` stays 0 for a full 2^addr_bits cycles after `rst` falls, and `doa`/`dob` read 0.
- `en`=0 hold:
  - after a read returns 16'h1234, drop `en` and change `addra`/`addrb`/`we`;
  - `doa`/`dob` stay at 16'h1234 and the RAM contents are unchanged.

Source files
------------

// File: rtl/ram_d_clr.sv
// ram_d_clr: single-clock dual-port RAM for neighbour/side-info storage.
// Port A is read/write (read-first), port B is read-only. A built-in clear engine
// sweeps every entry to clear_val after reset or on a clr request. ready is low while
// the sweep runs.
//
// Ports:
//   clk    rising-edge clock
//   rst    synchronous active-high reset; starts a full clear
//   clr    single-cycle re-clear request, honoured only when ready
//   en     access enable for both ports (ignored while clearing)
//   we     port A write enable, qualified by en
//   addra  port A address
//   addrb  port B address
//   dia    port A write data
//   doa    port A registered read data
//   dob    port B registered read data
//   ready  1 when user accesses are accepted
module ram_d_clr #(
  parameter int unsigned            addr_bits = 8,
  parameter int unsigned            data_bits = 16,
  parameter logic [data_bits-1:0]   clear_val = '0,
  parameter bit                     fwd_en    = 1'b1
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 clr,
  input  logic                 en,
  input  logic                 we,
  input  logic [addr_bits-1:0] addra,
  input  logic [addr_bits-1:0] addrb,
  input  logic [data_bits-1:0] dia,
  output logic [data_bits-1:0] doa,
  output logic [data_bits-1:0] dob,
  output logic                 ready
);

  localparam int unsigned Depth = 2 ** addr_bits;

  typedef enum logic [0:0] {StClear, StReady} state_e;

  state_e                 state_q, state_d;
  logic [addr_bits-1:0]   clr_addr_q, clr_addr_d;

  logic [data_bits-1:0]   mem [Depth];

  logic                   mem_we;
  logic [addr_bits-1:0]   mem_waddr;
  logic [data_bits-1:0]   mem_wdata;
  logic                   rd_en;
  logic                   fwd_hit;

  always_comb begin
    state_d    = state_q;
    clr_addr_d = clr_addr_q;
    mem_we     = 1'b0;
    mem_waddr  = addra;
    mem_wdata  = dia;
    rd_en      = 1'b0;
    unique case (state_q)
      StClear: begin
        mem_we     = 1'b1;
        mem_waddr  = clr_addr_q;
        mem_wdata  = clear_val;
        clr_addr_d = clr_addr_q + 1'b1;
        if (clr_addr_q == {addr_bits{1'b1}}) begin
          state_d = StReady;
        end
      end
      StReady: begin
        // A clr request drops the user access issued in the same cycle.
        if (clr) begin
          state_d    = StClear;
          clr_addr_d = '0;
        end else if (en) begin
          rd_en  = 1'b1;
          mem_we = we;
        end
      end
      default: begin
        state_d    = StClear;
        clr_addr_d = '0;
      end
    endcase
  end

  assign fwd_hit = fwd_en && we && (addrb == addra);
  assign ready   = (state_q == StReady);

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= StClear;
      clr_addr_q <= '0;
    end else begin
      state_q    <= state_d;
      clr_addr_q <= clr_addr_d;
    end
  end

  // Array kept free of reset so it maps onto block RAM; rst only suppresses the write.
  always_ff @(posedge clk) begin
    if (mem_we && !rst) begin
      mem[mem_waddr] <= mem_wdata;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      doa <= '0;
      dob <= '0;
    end else if (rd_en) begin
      doa <= mem[addra];
      dob <= fwd_hit ? dia : mem[addrb];
    end
  end

endmodule

// File: tb/tb_ram_d_clr.sv
module tb_ram_d_clr;

  localparam int unsigned AW = 4;
  localparam int unsigned DW = 16;
  localparam logic [DW-1:0] CV = 16'h5A5A;

  logic          clk = 1'b0;
  logic          rst, clr, en, we;
  logic [AW-1:0] addra, addrb;
  logic [DW-1:0] dia;
  logic [DW-1:0] doa, dob, doa_n, dob_n;
  logic          ready, ready_n;

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  ram_d_clr #(.addr_bits(AW), .data_bits(DW), .clear_val(CV), .fwd_en(1'b1)) u_dut_fwd (
    .clk(clk), .rst(rst), .clr(clr), .en(en), .we(we), .addra(addra), .addrb(addrb),
    .dia(dia), .doa(doa), .dob(dob), .ready(ready)
  );

  ram_d_clr #(.addr_bits(AW), .data_bits(DW), .clear_val(CV), .fwd_en(1'b0)) u_dut_nofwd (
    .clk(clk), .rst(rst), .clr(clr), .en(en), .we(we), .addra(addra), .addrb(addrb),
    .dia(dia), .doa(doa_n), .dob(dob_n), .ready(ready_n)
  );

  // Advance one edge; outputs are sampled and inputs changed 1 time unit after it.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    en = 1'b0; we = 1'b0; clr = 1'b0;
  endtask

  task automatic wr(input logic [AW-1:0] a, input logic [DW-1:0] d);
    en = 1'b1; we = 1'b1; addra = a; addrb = a + 4'd1; dia = d;
    tick();
    idle();
  endtask

  task automatic rd(input logic [AW-1:0] a, input logic [AW-1:0] b);
    en = 1'b1; we = 1'b0; addra = a; addrb = b;
    tick();
    idle();
  endtask

  // Expects ready low after the current edge and 15 more, high after the 16th.
  task automatic check_sweep(input string name);
    int low_cnt = 0;
    checks++;
    if (ready !== 1'b0 || ready_n !== 1'b0) begin
      errors++;
      $display("FAIL %s start: ready=%b/%b required 0", name, ready, ready_n);
    end
    for (int i = 1; i < 16; i++) begin
      tick();
      if (ready === 1'b0) low_cnt++;
    end
    checks++;
    if (low_cnt != 15) begin
      errors++;
      $display("FAIL %s low_cycles: got %0d required 15", name, low_cnt);
    end
    tick();
    checks++;
    if (ready !== 1'b1 || ready_n !== 1'b1) begin
      errors++;
      $display("FAIL %s end: ready=%b/%b required 1", name, ready, ready_n);
    end
  endtask

  task automatic check_all_clear(input string name);
    for (int i = 0; i < 16; i++) begin
      rd(AW'(i), AW'(15 - i));
      checks++;
      if (doa !== CV || dob !== CV || doa_n !== CV || dob_n !== CV) begin
        errors++;
        $display("FAIL %s addr %0d: doa=%h dob=%h doa_n=%h dob_n=%h required %h",
                 name, i, doa, dob, doa_n, dob_n, CV);
      end
    end
  endtask

  task automatic test_reset();
    rst = 1'b1; idle(); addra = '0; addrb = '0; dia = '0;
    tick();
    tick();
    rst = 1'b0;
    checks++;
    if (doa !== 16'h0 || dob !== 16'h0 || doa_n !== 16'h0 || dob_n !== 16'h0) begin
      errors++;
      $display("FAIL reset_out: doa=%h dob=%h required 0000", doa, dob);
    end
    check_sweep("reset_sweep");
    check_all_clear("reset_clear");
  endtask

  task automatic test_basic();
    wr(4'd3, 16'h1234);
    rd(4'd3, 4'd3);
    checks++;
    if (doa !== 16'h1234 || dob !== 16'h1234 || dob_n !== 16'h1234) begin
      errors++;
      $display("FAIL basic_rw: doa=%h dob=%h dob_n=%h required 1234", doa, dob, dob_n);
    end
  endtask

  task automatic test_collision();
    wr(4'd7, 16'hAAAA);
    en = 1'b1; we = 1'b1; addra = 4'd7; addrb = 4'd7; dia = 16'hBBBB;
    tick();
    idle();
    checks++;
    if (doa !== 16'hAAAA || doa_n !== 16'hAAAA) begin
      errors++;
      $display("FAIL coll_doa: doa=%h doa_n=%h required aaaa", doa, doa_n);
    end
    checks++;
    if (dob !== 16'hBBBB) begin
      errors++;
      $display("FAIL coll_dob_fwd: dob=%h required bbbb", dob);
    end
    checks++;
    if (dob_n !== 16'hAAAA) begin
      errors++;
      $display("FAIL coll_dob_nofwd: dob=%h required aaaa", dob_n);
    end
    rd(4'd7, 4'd7);
    checks++;
    if (doa !== 16'hBBBB || dob_n !== 16'hBBBB) begin
      errors++;
      $display("FAIL coll_after: doa=%h dob_n=%h required bbbb", doa, dob_n);
    end
  endtask

  task automatic test_en_hold();
    rd(4'd3, 4'd3);
    en = 1'b0; we = 1'b1; addra = 4'd5; addrb = 4'd6; dia = 16'hDEAD;
    tick();
    tick();
    checks++;
    if (doa !== 16'h1234 || dob !== 16'h1234 || doa_n !== 16'h1234) begin
      errors++;
      $display("FAIL en_hold: doa=%h dob=%h required 1234", doa, dob);
    end
    idle();
    rd(4'd5, 4'd6);
    checks++;
    if (doa !== CV || dob !== CV) begin
      errors++;
      $display("FAIL en_nowrite: doa=%h dob=%h required %h", doa, dob, CV);
    end
  endtask

  task automatic test_clr_traffic();
    for (int i = 0; i < 16; i++) wr(AW'(i), DW'(16'h1000 + i));
    rd(4'd1, 4'd9);
    checks++;
    if (doa !== 16'h1001 || dob !== 16'h1009) begin
      errors++;
      $display("FAIL fill: doa=%h dob=%h required 1001/1009", doa, dob);
    end
    clr = 1'b1; en = 1'b1; we = 1'b1; addra = 4'd2; addrb = 4'd2; dia = 16'hFFFF;
    tick();
    clr = 1'b0;
    // Hammer writes to address 0 throughout the sweep; all must be ignored.
    addra = 4'd0; addrb = 4'd0; dia = 16'hDEAD;
    check_sweep("clr_sweep");
    idle();
    checks++;
    if (doa !== 16'h1001 || dob !== 16'h1009) begin
      errors++;
      $display("FAIL clr_hold: doa=%h dob=%h required 1001/1009", doa, dob);
    end
    check_all_clear("clr_clear");
  endtask

  task automatic test_reset_mid_clear();
    wr(4'd4, 16'h4444);
    clr = 1'b1;
    tick();
    clr = 1'b0;
    for (int i = 0; i < 5; i++) tick();
    // A clr during CLEAR must not queue another sweep.
    clr = 1'b1;
    rst = 1'b1;
    tick();
    rst = 1'b0;
    clr = 1'b0;
    checks++;
    if (doa !== 16'h0 || dob !== 16'h0 || dob_n !== 16'h0) begin
      errors++;
      $display("FAIL midrst_out: doa=%h dob=%h required 0000", doa, dob);
    end
    check_sweep("midrst_sweep");
    tick();
    checks++;
    if (ready !== 1'b1) begin
      errors++;
      $display("FAIL midrst_noqueue: ready=%b required 1", ready);
    end
    check_all_clear("midrst_clear");
  endtask

  initial begin
    test_reset();
    test_basic();
    test_collision();
    test_en_hold();
    test_clr_traffic();
    test_reset_mid_clear();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
